mpu_acc_writeback: RTL

- Drains the MPU's 16 x 32-bit accumulator bank back to DRAM over the byte-wide DRAM bus. It is the write-direction counterpart of the MPU's DRAM read path.
- On start it snapshots all accumulators and pulses a clear request to the MPU. It then streams bytes out with a valid/ready handshake, in one of two formats:
  - raw 32-bit little-endian, or
  - requantized int8 (arithmetic shift, then signed saturation).

---
 rtl/mpu_pkg.sv | 25 ++
 rtl/mpu_acc_writeback_if.sv | 23 ++
 rtl/acc_requant.sv | 22 ++
 rtl/mpu_acc_writeback.sv | 126 ++++++++++++
 4 files changed

// File: rtl/mpu_pkg.sv
// Shared constants and types for the MPU accumulator write-back path.
package mpu_pkg;
    localparam int NUM_ACC = 16;
    localparam int ACC_W   = 32;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 8;

    typedef logic signed [ACC_W-1:0] acc_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } wb_state_t;

    typedef enum logic {
        WB_RAW  = 1'b0,
        WB_INT8 = 1'b1
    } wb_mode_t;

    // Index of the final byte of one accumulator in the given format.
    function automatic logic [1:0] last_byte_idx(input wb_mode_t m);
        return (m == WB_RAW) ? 2'd3 : 2'd0;
    endfunction
endpackage

// File: rtl/mpu_acc_writeback_if.sv
// Byte-wide DRAM write bus with valid/ready handshake.
interface mpu_acc_writeback_if;
    import mpu_pkg::*;

    logic              dram_wr_valid;
    logic              dram_wr_ready;
    logic [ADDR_W-1:0] dram_addr_bus;
    logic [DATA_W-1:0] dram_data_bus;

    modport master (
        output dram_wr_valid,
        output dram_addr_bus,
        output dram_data_bus,
        input  dram_wr_ready
    );

    modport slave (
        input  dram_wr_valid,
        input  dram_addr_bus,
        input  dram_data_bus,
        output dram_wr_ready
    );
endinterface

// File: rtl/acc_requant.sv
// Requantizes a signed 32-bit accumulator to int8: arithmetic shift, then signed saturation.
module acc_requant
    import mpu_pkg::*;
(
    input  acc_t              acc_i,
    input  logic [4:0]        shamt_i,
    output logic [DATA_W-1:0] q_o
);
    acc_t shifted_s;

    // Shift then clamp to the int8 range.
    always_comb begin
        shifted_s = acc_i >>> shamt_i;
        if (shifted_s > 32'sd127) begin
            q_o = 8'h7F;
        end else if (shifted_s < -32'sd128) begin
            q_o = 8'h80;
        end else begin
            q_o = shifted_s[7:0];
        end
    end
endmodule

// File: rtl/mpu_acc_writeback.sv
// Drains a snapshot of the MPU accumulator bank to DRAM, raw little-endian or int8 requantized.
module mpu_acc_writeback
    import mpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              mode,
    input  logic [4:0]        shamt,
    input  acc_t              acc_in [0:NUM_ACC-1],
    output logic              acc_clear,
    output logic              busy,
    output logic              done,
    mpu_acc_writeback_if.master wr
);
    wb_state_t         state_q, state_d;
    acc_t              snap_q [0:NUM_ACC-1];
    wb_mode_t          mode_q;
    logic [4:0]        shamt_q;
    logic [3:0]        acc_idx_q;
    logic [1:0]        byte_idx_q;
    logic [ADDR_W-1:0] addr_q;
    logic              clr_q;

    acc_t              cur_acc_s;
    logic [DATA_W-1:0] int8_s;
    logic [DATA_W-1:0] raw_byte_s;
    logic              xfer_s;
    logic              last_xfer_s;

    assign cur_acc_s   = snap_q[acc_idx_q];
    assign raw_byte_s  = cur_acc_s[{byte_idx_q, 3'b000} +: DATA_W];
    assign xfer_s      = (state_q == SEND) && wr.dram_wr_ready;
    assign last_xfer_s = xfer_s && (acc_idx_q == 4'd15) &&
                         (byte_idx_q == last_byte_idx(mode_q));

    acc_requant u_requant (
        .acc_i   (cur_acc_s),
        .shamt_i (shamt_q),
        .q_o     (int8_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEND;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (last_xfer_s) begin
                    state_d = DONE;
                end else begin
                    state_d = SEND;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Snapshot, job parameters and stream position.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ACC; i++) begin
                snap_q[i] <= '0;
            end
            mode_q     <= WB_RAW;
            shamt_q    <= 5'd0;
            acc_idx_q  <= 4'd0;
            byte_idx_q <= 2'd0;
            addr_q     <= '0;
            clr_q      <= 1'b0;
        end else begin
            clr_q <= (state_q == IDLE) && start;
            if ((state_q == IDLE) && start) begin
                for (int i = 0; i < NUM_ACC; i++) begin
                    snap_q[i] <= acc_in[i];
                end
                mode_q     <= wb_mode_t'(mode);
                shamt_q    <= shamt;
                acc_idx_q  <= 4'd0;
                byte_idx_q <= 2'd0;
                addr_q     <= base_addr;
            end else if (xfer_s) begin
                addr_q <= addr_q + 16'd1;
                if (byte_idx_q == last_byte_idx(mode_q)) begin
                    byte_idx_q <= 2'd0;
                    acc_idx_q  <= acc_idx_q + 4'd1;
                end else begin
                    byte_idx_q <= byte_idx_q + 2'd1;
                end
            end else begin
                addr_q <= addr_q;
            end
        end
    end

    // Outputs decoded from registered state; data is muxed straight from the snapshot.
    always_comb begin
        wr.dram_wr_valid = (state_q == SEND);
        wr.dram_addr_bus = addr_q;
        busy             = (state_q != IDLE);
        done             = (state_q == DONE);
        acc_clear        = clr_q;
        if (mode_q == WB_INT8) begin
            wr.dram_data_bus = int8_s;
        end else begin
            wr.dram_data_bus = raw_byte_s;
        end
    end
endmodule
